nic_link_allocator: RTL

//   Link allocation (LA) stage directly downstream of the NIC output packet buffers.

---
 rtl/nic_link_allocator.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/nic_link_allocator.sv
// nic_link_allocator
//   Link allocation stage between the NIC output packet buffers and the single
//   NIC->router link. Round-robin arbitration of buffer link requests with
//   one-hot grants, a registered flit mux onto the link, credit steering back
//   to the buffer owning the credited VC, and a sticky protocol error flag.
//   Optional packet-level (wormhole) locking is enabled by defining the macro
//   NIC_LA_PACKET_LOCK_EN; without it arbitration is flit-level round-robin.
//   Flit format macros normally come from NIC-defines.v; fallbacks below.

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 34
`endif
`ifndef FLIT_TYPE_BITS
`define FLIT_TYPE_BITS 33:32
`endif
`ifndef HEAD_FLIT
`define HEAD_FLIT 2'b10
`endif
`ifndef BODY_FLIT
`define BODY_FLIT 2'b00
`endif
`ifndef TAIL_FLIT
`define TAIL_FLIT 2'b01
`endif
`ifndef HEAD_TAIL_FLIT
`define HEAD_TAIL_FLIT 2'b11
`endif

module nic_link_allocator #(
  parameter int unsigned N_BUFFERS    = 4,
  parameter int unsigned N_BITS_VC_ID = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_BUFFERS-1:0]                 r_la_i,
  output logic [N_BUFFERS-1:0]                 g_la_o,
  input  logic [N_BUFFERS*`FLIT_WIDTH-1:0]     flits_i,
  input  logic [N_BUFFERS-1:0]                 is_valid_i,
  input  logic [N_BUFFERS*N_BITS_VC_ID-1:0]    vc_ids_i,
  input  logic                                 link_stall_i,
  output logic [`FLIT_WIDTH-1:0]               link_flit_o,
  output logic                                 link_valid_o,
  input  logic                                 link_credit_i,
  input  logic [N_BITS_VC_ID-1:0]              link_credit_vc_i,
  output logic [N_BUFFERS-1:0]                 credit_out_o,
  output logic                                 protocol_err_o
);

  localparam int unsigned FW = `FLIT_WIDTH;
  localparam int unsigned VW = N_BITS_VC_ID;
  localparam int unsigned IW = (N_BUFFERS > 1) ? $clog2(N_BUFFERS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BUFFERS - 1);

  // Arbitration
  logic [IW-1:0]        rr_ptr;
  logic [N_BUFFERS-1:0] eligible;
  logic [N_BUFFERS-1:0] grant;
  logic                 found;
  logic                 grant_valid;
  logic [IW-1:0]        grant_idx;
  logic [IW-1:0]        cand_idx;

  // Selected buffer, one cycle behind the grant
  logic [IW-1:0]        sel_idx;
  logic                 sel_valid;
  logic [FW-1:0]        sel_flit;
  logic                 sel_is_valid;
  logic                 capture;

  // Protocol checking
  logic [N_BUFFERS-1:0] valid_expected;
  logic                 flit_drop;
  logic                 stray_valid;

  // Credit steering
  logic [N_BUFFERS-1:0] credit_match;
  logic                 credit_err;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IW'(1);
  endfunction

  function automatic logic [N_BUFFERS-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_BUFFERS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef NIC_LA_PACKET_LOCK_EN
  typedef enum logic {
    LA_FREE,
    LA_LOCKED
  } lock_state_t;

  lock_state_t   lock_state;
  lock_state_t   lock_state_nxt;
  logic [IW-1:0] lock_idx;
  logic          tail_flit;
  logic          lock_clear;

  // Request masking: stall blocks every new grant; an open packet keeps the link for its owner.
  always_comb begin
    eligible = r_la_i & ~{N_BUFFERS{link_stall_i}};
    if (lock_state == LA_LOCKED) begin
      eligible = eligible & onehot(lock_idx);
    end
  end
`else
  // Request masking: stall blocks every new grant.
  always_comb begin
    eligible = r_la_i & ~{N_BUFFERS{link_stall_i}};
  end
`endif

  // Round-robin search: first eligible requester at or above rr_ptr, wrapping.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < N_BUFFERS; k++) begin
      cand_idx = IW'((32'(rr_ptr) + k) % N_BUFFERS);
      if (!found && eligible[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign grant_valid = found && !rst;

  // One-hot grant vector, forced low while in reset.
  always_comb begin
    grant = '0;
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign g_la_o = grant;

  // Selection register: remembers which buffer was granted for the capture cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_valid <= 1'b0;
      sel_idx   <= '0;
    end else begin
      sel_valid <= grant_valid;
      if (grant_valid) begin
        sel_idx <= grant_idx;
      end
    end
  end

  assign sel_flit     = flits_i[sel_idx*FW +: FW];
  assign sel_is_valid = is_valid_i[sel_idx];
  assign capture      = sel_valid && sel_is_valid;

`ifdef NIC_LA_PACKET_LOCK_EN
  assign tail_flit  = (sel_flit[`FLIT_TYPE_BITS] == `TAIL_FLIT) ||
                      (sel_flit[`FLIT_TYPE_BITS] == `HEAD_TAIL_FLIT);
  assign lock_clear = (lock_state == LA_LOCKED) && capture && (sel_idx == lock_idx) && tail_flit;

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state <= LA_FREE;
    end else begin
      lock_state <= lock_state_nxt;
    end
  end

  // Lock next state: open on any grant while free, close when the owner's tail is captured.
  always_comb begin
    lock_state_nxt = lock_state;
    case (lock_state)
      LA_FREE:   if (grant_valid) lock_state_nxt = LA_LOCKED;
      LA_LOCKED: if (lock_clear)  lock_state_nxt = LA_FREE;
      default:   lock_state_nxt = LA_FREE;
    endcase
  end

  // Lock owner and round-robin pointer; the pointer only moves when a packet closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else begin
      if ((lock_state == LA_FREE) && grant_valid) begin
        lock_idx <= grant_idx;
      end
      if (lock_clear) begin
        rr_ptr <= next_idx(lock_idx);
      end
    end
  end
`else
  // Round-robin pointer: move just past every granted buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= next_idx(grant_idx);
    end
  end
`endif

  // Link output register: flit and valid land two cycles after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_valid_o <= 1'b0;
      link_flit_o  <= '0;
    end else begin
      link_valid_o <= capture;
      if (capture) begin
        link_flit_o <= sel_flit;
      end
    end
  end

  // Credit match per buffer. An all-zero one-hot id names no VC, so it never matches.
  always_comb begin
    credit_match = '0;
    for (int unsigned k = 0; k < N_BUFFERS; k++) begin
      credit_match[k] = (link_credit_vc_i != '0) && (vc_ids_i[k*VW +: VW] == link_credit_vc_i);
    end
  end

  assign credit_err = link_credit_i &&
                      ((credit_match == '0) ||
                       ((credit_match & (credit_match - N_BUFFERS'(1))) != '0));

  // Credit return register: every matching buffer receives the credit one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_out_o <= '0;
    end else begin
      credit_out_o <= credit_match & {N_BUFFERS{link_credit_i}};
    end
  end

  assign valid_expected = sel_valid ? onehot(sel_idx) : '0;
  assign flit_drop      = sel_valid && !sel_is_valid;
  assign stray_valid    = (is_valid_i & ~valid_expected) != '0;

  // Sticky protocol error: dropped flit, unexpected valid or unroutable credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_err_o <= 1'b0;
    end else if (flit_drop || stray_valid || credit_err) begin
      protocol_err_o <= 1'b1;
    end
  end

endmodule
